// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key map, default timing.
package keypad_pkg;

  localparam int SCAN_DIV_DEF     = 50000;
  localparam int DEBOUNCE_CNT_DEF = 20;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } kstate_e;

  // Nibble {row,col} holds the key code; r0c0 in the LSBs.
  localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    return KEYMAP[{r, c, 2'b00} +: 4];
  endfunction

  function automatic logic onehot_low(input logic [3:0] s);
    return (s == 4'b1110) || (s == 4'b1101) || (s == 4'b1011) || (s == 4'b0111);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] s);
    logic [1:0] idx;
    idx = 2'd0;
    case (s)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// Free-running scan divider: one-cycle tick every SCAN_DIV clocks.
module scan_tick #(
  parameter int SCAN_DIV = keypad_pkg::SCAN_DIV_DEF
) (
  input  logic ck1,
  input  logic rst,
  output logic tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] div;

  always_ff @(posedge ck1) begin
    if (rst) begin
      div <= '0;
    end else if (div == CW'(SCAN_DIV - 1)) begin
      div <= '0;
    end else begin
      div <= div + CW'(1);
    end
  end

  assign tick = (div == CW'(SCAN_DIV - 1));

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with press/release debounce and a four-digit key history.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = SCAN_DIV_DEF,
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
  input  logic        ck1,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [15:0] q,
  output logic [3:0]  key,
  output logic        key_valid
);

  localparam int DW = $clog2(DEBOUNCE_CNT + 2);

  logic [3:0]    row_p0, row_p1;
  logic          tick;
  kstate_e       state, state_n;
  logic [1:0]    cidx, cidx_n;
  logic [3:0]    cap, cap_n;
  logic [DW-1:0] dcnt, dcnt_n, dcnt_inc;
  logic          accept;
  logic [3:0]    kcode;

  scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .ck1  (ck1),
    .rst  (rst),
    .tick (tick)
  );

  // Stage p0/p1: two-flop synchronizer for the asynchronous row lines
  always_ff @(posedge ck1) begin
    if (rst) begin
      row_p0 <= 4'hF;
      row_p1 <= 4'hF;
    end else begin
      row_p0 <= row;
      row_p1 <= row_p0;
    end
  end

  assign dcnt_inc = dcnt + DW'(1);
  assign kcode    = key_lookup(low_index(cap), cidx);

  always_comb begin
    state_n = state;
    cidx_n  = cidx;
    cap_n   = cap;
    dcnt_n  = dcnt;
    accept  = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          // Multi-row patterns are ambiguous and treated like an idle column.
          if (onehot_low(row_p1)) begin
            state_n = DEBOUNCE;
            cap_n   = row_p1;
            dcnt_n  = DW'(1);
          end else begin
            cidx_n = cidx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (row_p1 == cap) begin
            if (dcnt_inc >= DW'(DEBOUNCE_CNT)) begin
              state_n = PRESSED;
              accept  = 1'b1;
              dcnt_n  = '0;
            end else begin
              dcnt_n = dcnt_inc;
            end
          end else begin
            state_n = SCAN;
            cidx_n  = cidx + 2'd1;
            dcnt_n  = '0;
          end
        end
        PRESSED: begin
          if (row_p1 == 4'hF) begin
            state_n = RELEASE;
            dcnt_n  = DW'(1);
          end
        end
        RELEASE: begin
          if (row_p1 != 4'hF) begin
            state_n = PRESSED;
            dcnt_n  = '0;
          end else if (dcnt_inc >= DW'(DEBOUNCE_CNT)) begin
            state_n = SCAN;
            cidx_n  = cidx + 2'd1;
            dcnt_n  = '0;
          end else begin
            dcnt_n = dcnt_inc;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end

  always_ff @(posedge ck1) begin
    if (rst) begin
      state     <= SCAN;
      cidx      <= 2'd0;
      cap       <= 4'hF;
      dcnt      <= '0;
      q         <= 16'h0000;
      key       <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_n;
      cidx      <= cidx_n;
      cap       <= cap_n;
      dcnt      <= dcnt_n;
      key_valid <= accept;
      if (accept) begin
        key <= kcode;
        q   <= {q[11:0], kcode};
      end
    end
  end

  assign col = ~(4'b0001 << cidx);

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_CNT=3 and a column-gated keypad model.
module tb_keypad_scan;

  logic        ck1;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] q;
  logic [3:0]  key;
  logic        key_valid;

  logic [3:0]  rowmask;
  logic [1:0]  pcol;
  logic        use_force;
  logic [3:0]  force_row;

  int vectors;
  int miscompares;
  int kv_count;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .ck1       (ck1),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .q         (q),
    .key       (key),
    .key_valid (key_valid)
  );

  // Pressed keys pull their row low only while their column is strobed.
  assign row = use_force ? force_row :
               ((col == ~(4'b0001 << pcol)) ? ~rowmask : 4'hF);

  initial ck1 = 1'b0;
  always #5 ck1 = ~ck1;

  always @(negedge ck1) begin
    if (key_valid) kv_count <= kv_count + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge ck1);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clk_n(3);
    rst = 1'b0;
  endtask

  task automatic wait_kv(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      clk_n(1);
      if (key_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_col(input logic [3:0] want, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      clk_n(1);
      if (col === want) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic press(input string tag, input logic [1:0] r, input logic [1:0] c,
                       input logic [3:0] ekey, input logic [15:0] eq);
    int   k0;
    logic ok;
    k0      = kv_count;
    pcol    = c;
    rowmask = 4'b0001 << r;
    wait_kv(ok);
    chk({tag, "_accept"}, {15'd0, ok}, 16'd1);
    chk({tag, "_key"}, {12'd0, key}, {12'd0, ekey});
    chk({tag, "_q"}, q, eq);
    chk({tag, "_col"}, {12'd0, col}, {12'd0, ~(4'b0001 << c)});
    clk_n(60);
    chk({tag, "_colheld"}, {12'd0, col}, {12'd0, ~(4'b0001 << c)});
    chk({tag, "_onepulse"}, 16'(kv_count - k0), 16'd1);
    rowmask = 4'h0;
    clk_n(60);
    chk({tag, "_norepeat"}, 16'(kv_count - k0), 16'd1);
  endtask

  initial begin
    int          k0;
    logic        ok;
    logic [3:0]  e;
    vectors     = 0;
    miscompares = 0;
    kv_count    = 0;
    rst         = 1'b1;
    rowmask     = 4'h0;
    pcol        = 2'd0;
    use_force   = 1'b0;
    force_row   = 4'hF;

    // Reset values and idle column rotation
    do_reset();
    chk("rst_col", {12'd0, col}, 16'h000E);
    chk("rst_q", q, 16'h0000);
    chk("rst_key", {12'd0, key}, 16'h0000);
    chk("rst_kv", {15'd0, key_valid}, 16'h0000);
    for (int i = 1; i <= 10; i++) begin
      clk_n(4);
      e = ~(4'b0001 << (i % 4));
      chk("idle_col", {12'd0, col}, {12'd0, e});
    end
    chk("idle_nokv", 16'(kv_count), 16'd0);
    chk("idle_q", q, 16'h0000);

    // Single key '6' held for many ticks
    do_reset();
    press("key6", 2'd1, 2'd2, 4'h6, 16'h0006);

    // Key sequence into the history register
    press("key1", 2'd0, 2'd0, 4'h1, 16'h0061);
    press("key2", 2'd0, 2'd1, 4'h2, 16'h0612);
    press("key3", 2'd0, 2'd2, 4'h3, 16'h6123);
    press("key0", 2'd3, 2'd1, 4'h0, 16'h1230);
    press("keyA", 2'd0, 2'd3, 4'hA, 16'h230A);

    // Reset during debounce of '5', key kept held
    k0 = kv_count;
    wait_col(4'b1110, ok);
    chk("k5_sync0", {15'd0, ok}, 16'd1);
    pcol    = 2'd1;
    rowmask = 4'b0010;
    wait_col(4'b1101, ok);
    chk("k5_sync1", {15'd0, ok}, 16'd1);
    clk_n(5);
    rst = 1'b1;
    clk_n(1);
    rst = 1'b0;
    chk("k5rst_col", {12'd0, col}, 16'h000E);
    chk("k5rst_q", q, 16'h0000);
    chk("k5rst_key", {12'd0, key}, 16'h0000);
    chk("k5rst_kv", {15'd0, key_valid}, 16'h0000);
    chk("k5rst_nokv", 16'(kv_count - k0), 16'd0);
    clk_n(8);
    chk("k5_frozen", {12'd0, col}, 16'h000D);
    clk_n(7);
    chk("k5_early", {15'd0, key_valid}, 16'h0000);
    clk_n(1);
    chk("k5_kv", {15'd0, key_valid}, 16'h0001);
    chk("k5_key", {12'd0, key}, 16'h0005);
    chk("k5_q", q, 16'h0005);
    rowmask = 4'h0;
    clk_n(60);
    chk("k5_once", 16'(kv_count - k0), 16'd1);

    // Bounce: low 2 ticks, high 1, low 2
    k0        = kv_count;
    use_force = 1'b1;
    force_row = 4'b1110;
    do_reset();
    clk_n(4);
    chk("bnc_frz0", {12'd0, col}, 16'h000E);
    clk_n(4);
    force_row = 4'hF;
    clk_n(4);
    chk("bnc_rot1", {12'd0, col}, 16'h000D);
    force_row = 4'b1110;
    clk_n(8);
    chk("bnc_frz1", {12'd0, col}, 16'h000D);
    force_row = 4'hF;
    clk_n(4);
    chk("bnc_rot2", {12'd0, col}, 16'h000B);
    clk_n(4);
    chk("bnc_rot3", {12'd0, col}, 16'h0007);
    chk("bnc_nokv", 16'(kv_count - k0), 16'd0);
    use_force = 1'b0;

    // Two keys in one column are rejected
    k0      = kv_count;
    pcol    = 2'd2;
    rowmask = 4'b0011;
    wait_col(4'b1011, ok);
    chk("dbl_sync", {15'd0, ok}, 16'd1);
    clk_n(4);
    chk("dbl_rot0", {12'd0, col}, 16'h0007);
    clk_n(4);
    chk("dbl_rot1", {12'd0, col}, 16'h000E);
    clk_n(80);
    chk("dbl_nokv", 16'(kv_count - k0), 16'd0);
    rowmask = 4'h0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000; ck1 cycles per scan tick (1 ms at 50 MHz).
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 20; consecutive matching ticks needed to accept a press or a release.
REQ-003 SHALL have port ck1  input  1  system clock, 50 MHz; single clock domain.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port row  input  4  keypad rows; active-low; externally pulled up; asynchronous.
REQ-006 SHALL have port col  output  4  keypad column strobes; active-low; exactly one column low at any time.
REQ-007 SHALL have port q  output  16  last four accepted key codes; newest in q[3:0]; drives the 4-digit display word.
REQ-008 SHALL have port key  output  4  hex code of the last accepted key.
REQ-009 SHALL have port key_valid  output  1  one-cycle pulse on key acceptance.

Function
REQ-010 SHALL pass row through a 2-flop synchronizer before any use; "row sample" means synchronized row at a tick.
REQ-011 SHALL generate tick: one ck1 cycle high every SCAN_DIV cycles from a free-running divider; divider wraps SCAN_DIV-1 -> 0.
REQ-012 SHALL implement FSM states SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-013 In SCAN, at each tick: row sample == 4'hF -> rotate col to next column (1110 -> 1101 -> 1011 -> 0111 -> 1110); else go to DEBOUNCE.
REQ-014 On SCAN -> DEBOUNCE, SHALL capture column index and row pattern, freeze col, and set debounce counter to 1.
REQ-015 A row sample that is not one-hot-low, such as 4'b1100, SHALL be treated as no key: stay in SCAN and rotate col normally.
REQ-016 In DEBOUNCE, at each tick: sample == captured pattern -> increment counter; any difference -> return to SCAN and resume rotation from the next column.
REQ-017 When the counter reaches DEBOUNCE_CNT, SHALL enter PRESSED and, in the same cycle, assert key_valid, load key, and load q <= {q[11:0], key}.
REQ-018 Key map (row r, col c): r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: E 0 F D (E = '*', F = '#').
REQ-019 In PRESSED, col SHALL stay frozen; at the first tick with sample == 4'hF, go to RELEASE with counter = 1.
REQ-020 In RELEASE, at each tick: sample == 4'hF -> increment; any low row -> back to PRESSED without a new key_valid; counter reaching DEBOUNCE_CNT -> SCAN, rotate to next column.
REQ-021 A held key SHALL produce exactly one key_valid; no auto-repeat.
REQ-022 A second key pressed while in PRESSED or RELEASE SHALL be ignored until full release.
REQ-023 key_valid SHALL be low in every cycle except the acceptance cycle.
REQ-024 key and q SHALL change only in the acceptance cycle.

Reset
REQ-025 While rst is high at a ck1 edge, SHALL force: state SCAN, col = 4'b1110, q = 16'h0000, key = 4'h0, key_valid = 0, divider and debounce counters = 0, synchronizer flops = 4'hF.
REQ-026 rst asserted mid-DEBOUNCE/PRESSED/RELEASE SHALL abort with no key_valid; a key still held after reset SHALL be re-detected and accepted once.

Structure
REQ-027 SHALL place the state enum, key-map constant table, and the SCAN_DIV/DEBOUNCE_CNT defaults in shared package keypad_pkg.
REQ-028 SHALL factor the tick divider into sub-module scan_tick (ck1, rst, tick; parameter SCAN_DIV); FSM, synchronizer, and q shift register stay in keypad_scan.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-029 No key pressed, 40 cycles after reset -> col cycles 1110, 1101, 1011, 0111, 1110 every 4 cycles; key_valid never asserted; q = 0000.
REQ-030 Hold row=1101 while col=1011 for 20 ticks -> exactly one key_valid; key = 4'h6; q = 0006; col frozen at 1011 until release.
REQ-031 Press sequence '1', '2', '3', '0', each with clean press and release -> q = 1230; then 'A' -> q = 230A.
REQ-032 Bounce: row low 2 ticks, high 1 tick, low 2 ticks -> no key_valid; FSM back in SCAN.
REQ-033 rst pulsed for 1 cycle during DEBOUNCE of '5' -> outputs at reset values; with key still held, one key_valid with key = 5 after 3 further matching ticks.
REQ-034 row=1100 (two keys in one column) -> no key_valid; col keeps rotating.
